// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and helpers for branch_predict_unit and its counter table.
package branch_predict_unit_pkg;

  localparam logic [3:0] OP_BRANCH = 4'b0010;

  // 2-bit saturating counter states
  localparam logic [1:0] CNT_SNT = 2'b00;  // strong not-taken
  localparam logic [1:0] CNT_WNT = 2'b01;  // weak not-taken
  localparam logic [1:0] CNT_WT  = 2'b10;  // weak taken
  localparam logic [1:0] CNT_ST  = 2'b11;  // strong taken

  localparam logic [1:0] CNT_RESET = CNT_WNT;

  // Move a counter one step toward the resolved outcome, saturating at the ends.
  function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == CNT_ST) ? CNT_ST : cnt + 2'b01;
    end
    return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predict_unit_bht_counter_table.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous training port.
module bht_counter_table
  import branch_predict_unit_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int IDX_BITS = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_cnt,
  input  logic                upd_en,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cnt_d [ENTRIES];

  // Read returns the registered value, so a same-cycle update is not bypassed.
  always_comb begin
    rd_cnt = cnt_q[rd_idx];
  end

  // Train only the addressed entry; all others hold.
  always_comb begin
    cnt_d = cnt_q;
    if (upd_en) begin
      cnt_d[upd_idx] = cnt_train(cnt_q[upd_idx], upd_taken);
    end
  end

  // Counter storage, all entries return to weak-not-taken on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_RESET;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch prediction / resolution unit: IF-stage lookup into a 2-bit counter
// table, EX-stage resolve with flush and redirect, table training and
// saturating performance counters.
// Optional build macro BPU_GSHARE_EN: XOR a non-speculative global history
// register into the lookup index.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int DBITS       = 32,
  parameter int BHT_ENTRIES = 16,
  parameter int IDX_BITS    = $clog2(BHT_ENTRIES),
  parameter int STAT_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DBITS-1:0]     IF_PC,
  output logic                 IF_predTaken,
  output logic [IDX_BITS-1:0]  IF_bhtIdx,
  input  logic                 EX_valid,
  input  logic [3:0]           EX_opcode,
  input  logic [DBITS-1:0]     EX_PC,
  input  logic [DBITS-1:0]     EX_PC_IMM,
  input  logic                 EX_condFlag,
  input  logic                 EX_pred,
  input  logic [IDX_BITS-1:0]  EX_bhtIdx,
  output logic                 correct,
  output logic                 flush,
  output logic [DBITS-1:0]     newPC,
  output logic [STAT_BITS-1:0] statBranches,
  output logic [STAT_BITS-1:0] statMispredicts
);

  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  logic                 resolve;
  logic                 mispredict;
  logic [DBITS-1:0]     pc_plus4;
  logic [IDX_BITS-1:0]  lookup_idx;
  logic [1:0]           lookup_cnt;

  logic [STAT_BITS-1:0] stat_br_q, stat_br_d;
  logic [STAT_BITS-1:0] stat_mp_q, stat_mp_d;

`ifdef BPU_GSHARE_EN
  logic [IDX_BITS-1:0]  ghr_q, ghr_d;

  // Lookup index hashes the PC with global history.
  always_comb begin
    lookup_idx = IF_PC[IDX_BITS+1:2] ^ ghr_q;
  end

  // History shifts in each resolved outcome; only real resolves touch it.
  always_comb begin
    ghr_d = ghr_q;
    if (resolve) begin
      ghr_d = (ghr_q << 1) | IDX_BITS'(EX_condFlag);
    end
  end

  // Global history register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  // Lookup index is the word-aligned PC bits only.
  always_comb begin
    lookup_idx = IF_PC[IDX_BITS+1:2];
  end
`endif

  bht_counter_table #(
    .ENTRIES  (BHT_ENTRIES),
    .IDX_BITS (IDX_BITS)
  ) u_bht (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_idx    (lookup_idx),
    .rd_cnt    (lookup_cnt),
    .upd_en    (resolve),
    .upd_idx   (EX_bhtIdx),
    .upd_taken (EX_condFlag)
  );

  // IF-side prediction is the counter MSB.
  always_comb begin
    IF_predTaken = lookup_cnt[1];
    IF_bhtIdx    = lookup_idx;
  end

  // EX-side resolve and redirect; fall-through target wraps modulo 2^DBITS.
  always_comb begin
    resolve    = EX_valid && (EX_opcode == OP_BRANCH);
    mispredict = resolve && (EX_condFlag != EX_pred);
    pc_plus4   = EX_PC + DBITS'(4);
    correct    = !mispredict;
    flush      = mispredict;
    newPC      = (mispredict && EX_condFlag) ? EX_PC_IMM : pc_plus4;
  end

  // Saturating statistic counters.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (resolve && (stat_br_q != STAT_MAX)) begin
      stat_br_d = stat_br_q + 1'b1;
    end
    if (mispredict && (stat_mp_q != STAT_MAX)) begin
      stat_mp_d = stat_mp_q + 1'b1;
    end
  end

  // Statistic registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign statBranches    = stat_br_q;
  assign statMispredicts = stat_mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed vector table,
// saturation / mid-operation reset sequences, then random traffic against
// a behavioural model.
module tb_branch_predict_unit;

  localparam int DBITS = 32;
  localparam int ENT   = 16;
  localparam int IDXB  = 4;
  localparam int SBITS = 4;
  localparam int SMAX  = (1 << SBITS) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [31:0]      IF_PC;
  logic             IF_predTaken;
  logic [IDXB-1:0]  IF_bhtIdx;
  logic             EX_valid;
  logic [3:0]       EX_opcode;
  logic [31:0]      EX_PC;
  logic [31:0]      EX_PC_IMM;
  logic             EX_condFlag;
  logic             EX_pred;
  logic [IDXB-1:0]  EX_bhtIdx;
  logic             correct;
  logic             flush;
  logic [31:0]      newPC;
  logic [SBITS-1:0] statBranches;
  logic [SBITS-1:0] statMispredicts;

  branch_predict_unit #(
    .DBITS(DBITS), .BHT_ENTRIES(ENT), .STAT_BITS(SBITS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .IF_PC(IF_PC), .IF_predTaken(IF_predTaken),
    .IF_bhtIdx(IF_bhtIdx), .EX_valid(EX_valid), .EX_opcode(EX_opcode),
    .EX_PC(EX_PC), .EX_PC_IMM(EX_PC_IMM), .EX_condFlag(EX_condFlag),
    .EX_pred(EX_pred), .EX_bhtIdx(EX_bhtIdx), .correct(correct), .flush(flush),
    .newPC(newPC), .statBranches(statBranches), .statMispredicts(statMispredicts)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: counters as small integers 0..3, plain integer stats.
  int m_cnt [ENT];
  int m_br, m_mp, m_ghr;

  task automatic model_reset();
    for (int i = 0; i < ENT; i++) m_cnt[i] = 1;
    m_br = 0; m_mp = 0; m_ghr = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] ifpc, input logic v, input logic [3:0] op,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic cond, input logic pred, input logic [IDXB-1:0] idx);
    IF_PC = ifpc; EX_valid = v; EX_opcode = op; EX_PC = pc; EX_PC_IMM = imm;
    EX_condFlag = cond; EX_pred = pred; EX_bhtIdx = idx;
  endtask

  // Check combinational outputs against the model, clock once, check stats.
  task automatic step();
    int  li;
    bit  res, mis;
    logic [31:0] exp_pc;
    #1;
    li = (int'(IF_PC) >> 2) % ENT;
`ifdef BPU_GSHARE_EN
    li = li ^ m_ghr;
`endif
    res = EX_valid && (EX_opcode == 4'd2);
    mis = res && (EX_condFlag != EX_pred);
    if (mis && EX_condFlag) exp_pc = EX_PC_IMM;
    else                    exp_pc = 32'(longint'(EX_PC) + 4);
    chk("m_idx",     64'(IF_bhtIdx),    64'(li));
    chk("m_pred",    64'(IF_predTaken), 64'(m_cnt[li] >= 2));
    chk("m_flush",   64'(flush),        64'(mis));
    chk("m_correct", 64'(correct),      64'(!mis));
    chk("m_newpc",   64'(newPC),        64'(exp_pc));
    if (res) begin
      if (EX_condFlag) m_cnt[EX_bhtIdx] = (m_cnt[EX_bhtIdx] < 3) ? m_cnt[EX_bhtIdx] + 1 : 3;
      else             m_cnt[EX_bhtIdx] = (m_cnt[EX_bhtIdx] > 0) ? m_cnt[EX_bhtIdx] - 1 : 0;
      m_ghr = ((m_ghr << 1) | int'(EX_condFlag)) % ENT;
      if (m_br < SMAX) m_br++;
      if (mis && m_mp < SMAX) m_mp++;
    end
    @(posedge clk); #1;
    chk("m_stat_br", 64'(statBranches),    64'(m_br));
    chk("m_stat_mp", 64'(statMispredicts), 64'(m_mp));
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] if_pc;
    logic        v;
    logic [3:0]  op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        cond;
    logic        pred;
    logic [3:0]  idx;
    logic        e_pred;
    logic [3:0]  e_idx;
    logic        e_flush;
    logic [31:0] e_newpc;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{32'h40, 1'b0, 4'h0, 32'h40, 32'h100, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h44};
    vecs[1]  = '{32'h40, 1'b1, 4'h2, 32'h40, 32'h100, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 32'h100};
    vecs[2]  = '{32'h40, 1'b0, 4'h0, 32'h40, 32'h100, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 32'h44};
    vecs[3]  = '{32'h0C, 1'b1, 4'h2, 32'h0C, 32'h200, 1'b1, 1'b0, 4'h3, 1'b0, 4'h3, 1'b1, 32'h200};
    vecs[4]  = '{32'h0C, 1'b1, 4'h2, 32'h0C, 32'h200, 1'b1, 1'b1, 4'h3, 1'b1, 4'h3, 1'b0, 32'h10};
    vecs[5]  = '{32'h0C, 1'b1, 4'h2, 32'h0C, 32'h200, 1'b1, 1'b1, 4'h3, 1'b1, 4'h3, 1'b0, 32'h10};
    vecs[6]  = '{32'h0C, 1'b1, 4'h2, 32'h0C, 32'h200, 1'b0, 1'b1, 4'h3, 1'b1, 4'h3, 1'b1, 32'h10};
    vecs[7]  = '{32'h0C, 1'b0, 4'h0, 32'h0C, 32'h200, 1'b0, 1'b0, 4'h3, 1'b1, 4'h3, 1'b0, 32'h10};
    vecs[8]  = '{32'h14, 1'b1, 4'h2, 32'hFFFFFFFC, 32'h500, 1'b0, 1'b1, 4'h5, 1'b0, 4'h5, 1'b1, 32'h0};
    vecs[9]  = '{32'h14, 1'b0, 4'h2, 32'h80, 32'h300, 1'b0, 1'b1, 4'h5, 1'b0, 4'h5, 1'b0, 32'h84};
    vecs[10] = '{32'h14, 1'b1, 4'h3, 32'h80, 32'h300, 1'b1, 1'b0, 4'h5, 1'b0, 4'h5, 1'b0, 32'h84};
    vecs[11] = '{32'h14, 1'b1, 4'h2, 32'h80, 32'h300, 1'b1, 1'b0, 4'h5, 1'b0, 4'h5, 1'b1, 32'h300};
    vecs[12] = '{32'h14, 1'b1, 4'h2, 32'h80, 32'h300, 1'b1, 1'b0, 4'h5, 1'b0, 4'h5, 1'b1, 32'h300};
    vecs[13] = '{32'h14, 1'b0, 4'h0, 32'h80, 32'h300, 1'b0, 1'b0, 4'h5, 1'b1, 4'h5, 1'b0, 32'h84};
    vecs[14] = '{32'h12345678, 1'b0, 4'h0, 32'h80, 32'h300, 1'b0, 1'b0, 4'h0, 1'b0, 4'hE, 1'b0, 32'h84};

    // Reset state; combinational outputs follow inputs while in reset.
    reset_n = 1'b0;
    drive(32'h40, 1'b0, 4'h0, 32'h40, 32'h100, 1'b0, 1'b0, 4'h0);
    model_reset();
    #2;
    chk("rst_pred",    64'(IF_predTaken),    64'(0));
    chk("rst_idx",     64'(IF_bhtIdx),       64'(0));
    chk("rst_stat_br", 64'(statBranches),    64'(0));
    chk("rst_stat_mp", 64'(statMispredicts), 64'(0));
    chk("rst_newpc",   64'(newPC),           64'h44);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

`ifndef BPU_GSHARE_EN
    // Directed vectors with hand-derived expectations (PC-only index).
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].if_pc, vecs[i].v, vecs[i].op, vecs[i].pc, vecs[i].imm,
            vecs[i].cond, vecs[i].pred, vecs[i].idx);
      #1;
      chk($sformatf("v%0d_pred", i),    64'(IF_predTaken), 64'(vecs[i].e_pred));
      chk($sformatf("v%0d_idx", i),     64'(IF_bhtIdx),    64'(vecs[i].e_idx));
      chk($sformatf("v%0d_flush", i),   64'(flush),        64'(vecs[i].e_flush));
      chk($sformatf("v%0d_correct", i), 64'(correct),      64'(!vecs[i].e_flush));
      chk($sformatf("v%0d_newpc", i),   64'(newPC),        64'(vecs[i].e_newpc));
      step();
    end
    chk("dir_stat_br", 64'(statBranches),    64'(8));
    chk("dir_stat_mp", 64'(statMispredicts), 64'(6));
`else
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].if_pc, vecs[i].v, vecs[i].op, vecs[i].pc, vecs[i].imm,
            vecs[i].cond, vecs[i].pred, vecs[i].idx);
      step();
    end
`endif

    // Drive both statistic counters into saturation and beyond.
    for (int i = 0; i < 12; i++) begin
      drive(32'h1C, 1'b1, 4'h2, 32'h1C, 32'h400, 1'(i % 2), 1'(!(i % 2)), 4'h7);
      step();
    end
    chk("sat_stat_mp", 64'(statMispredicts), 64'(SMAX));
    chk("sat_stat_br", 64'(statBranches),    64'(SMAX));

    // Reset asserted between edges clears state immediately; a live branch
    // held across the reset edge must not train anything.
    drive(32'h0C, 1'b1, 4'h2, 32'h0C, 32'h200, 1'b1, 1'b0, 4'h3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_stat_br", 64'(statBranches),    64'(0));
    chk("mid_rst_stat_mp", 64'(statMispredicts), 64'(0));
    chk("mid_rst_pred",    64'(IF_predTaken),    64'(0));
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    drive(32'h0C, 1'b0, 4'h0, 32'h0C, 32'h200, 1'b0, 1'b0, 4'h3);
    step();

`ifdef BPU_GSHARE_EN
    // Outcomes 1,0,1 from reset must leave history 0b101.
    drive(32'h0, 1'b1, 4'h2, 32'h0, 32'h0, 1'b1, 1'b1, 4'h0); step();
    drive(32'h0, 1'b1, 4'h2, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0); step();
    drive(32'h0, 1'b1, 4'h2, 32'h0, 32'h0, 1'b1, 1'b1, 4'h0); step();
    drive(32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0);
    #1;
    chk("ghr_101", 64'(IF_bhtIdx), 64'(5));
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 1) != 0) ? 4'h2 : 4'($urandom),
            $urandom, $urandom, 1'($urandom), 1'($urandom),
            IDXB'($urandom_range(0, 3)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch prediction and resolution unit for the 5-stage pipeline. It holds a table of 2-bit saturating counters that the IF stage reads to predict branches. In EX it compares the resolved condition against the carried prediction, produces the flush and redirect PC, and trains the table. It also keeps saturating branch and mispredict counters for performance readout.

## Interface
Parameters:
- DBITS, 32, PC and target width.
- BHT_ENTRIES, 16, counter table depth; power of two, 2 to 1024.
- IDX_BITS, $clog2(BHT_ENTRIES), table index width.
- STAT_BITS, 16, width of the statistic counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- IF_PC  in  DBITS  fetch PC for lookup.
- IF_predTaken  out  1  prediction for IF_PC; MSB of the indexed counter.
- IF_bhtIdx  out  IDX_BITS  index used for this lookup; the pipeline carries it to EX.
- EX_valid  in  1  EX holds a live instruction (not a bubble or squashed).
- EX_opcode  in  4  EX opcode; a branch is 4'b0010.
- EX_PC  in  DBITS  PC of the instruction in EX.
- EX_PC_IMM  in  DBITS  branch target (PC + imm).
- EX_condFlag  in  1  resolved outcome; 1 means taken.
- EX_pred  in  1  prediction carried from IF.
- EX_bhtIdx  in  IDX_BITS  index carried from IF.
- correct  out  1  1 unless a resolved branch mispredicted.
- flush  out  1  reset the IF and DEC pipeline registers.
- newPC  out  DBITS  redirect PC, valid when flush=1.
- statBranches  out  STAT_BITS  resolved branch count.
- statMispredicts  out  STAT_BITS  mispredict count.

## Operation
- Resolve event: EX_valid && EX_opcode==4'b0010.
- Lookup index: IF_PC[IDX_BITS+1:2] when BPU_GSHARE_EN is undefined.
- Counter encoding: 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken.
- On a resolve event:
  - Outcome taken: EX_bhtIdx counter increments, saturating at 11.
  - Outcome not taken: EX_bhtIdx counter decrements, saturating at 00.
  - statBranches increments, saturating at all-ones.
- Mispredict (EX_condFlag != EX_pred):
  - correct=0 and flush=1.
  - statMispredicts increments, saturating at all-ones.
  - Predicted taken, actual not taken: newPC = EX_PC + 4.
  - Predicted not taken, actual taken: newPC = EX_PC_IMM.
- Correct prediction, no resolve event, or EX_valid=0:
  - correct=1, flush=0, newPC = EX_PC + 4.
  - Non-resolve cycles cause no table or counter change.
- Addition is modulo 2^DBITS; EX_PC + 4 wraps silently.

## Timing
- IF_predTaken, IF_bhtIdx, correct, flush and newPC are combinational, in the same cycle as their inputs.
- Table, history and statistic updates become visible on the next rising edge.
- If a lookup and an update hit the same index in one cycle, the lookup returns the pre-update value. There is no bypass.
- Reset values:
  - Every counter is 01 (weak-not-taken).
  - GHR is 0.
  - statBranches and statMispredicts are 0.
  - Combinational outputs follow their inputs during reset.
- Reset asserted mid-operation clears state immediately. No update is lost or replayed after release.
- A flush cycle still trains the table. The squashed younger instructions arrive with EX_valid=0 and are ignored.

## Configuration
- BPU_GSHARE_EN defined:
  - Adds an IDX_BITS global history register (GHR).
  - Lookup index = IF_PC[IDX_BITS+1:2] ^ GHR.
  - On every resolve event the GHR shifts left and EX_condFlag enters at bit 0. This is non-speculative history.
  - Training still uses the carried EX_bhtIdx, so the GHR may change between lookup and update.
- BPU_GSHARE_EN undefined: no GHR; the index is the PC bits only.

## Structure
- Shared package holds:
  - the opcode constant OP_BRANCH = 4'b0010
  - the counter-state constants
  - the reset counter value
- One sub-module, bht_counter_table, holds the counter array:
  - one combinational read port and one synchronous saturating-update port
  - asynchronous reset of all entries
- The top level holds the resolve/redirect logic, the GHR and the statistic counters.

## Test plan
- Reset, then IF_PC=0x40 → IF_predTaken=0 and IF_bhtIdx=0x0; both stat counters 0.
- Branch at EX_PC=0x40, EX_pred=0, EX_condFlag=1, EX_PC_IMM=0x100, EX_bhtIdx=0 → flush=1, correct=0, newPC=0x100. Next cycle IF_PC=0x40 gives IF_predTaken=1.
- Three taken then one not-taken resolve at index 3 → counter path 01→10→11→11→10; prediction stays 1.
- EX_pred=1, EX_condFlag=0, EX_PC=0xFFFFFFFC → newPC=0x00000000 (wrap), flush=1.
- EX_valid=0 with the branch opcode, or a non-branch opcode → flush=0, no counter or stat change. Same-cycle lookup and update on the same index returns the old value.
- Force statMispredicts to all-ones by preload or long run, then one more mispredict → it holds all-ones. With BPU_GSHARE_EN, outcomes 1,0,1 from reset give GHR=0b101 (IDX_BITS=4).
